perf_monitor: RTL
=================

PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 Parameter WIDTH, default 32: width of every event counter.
REQ-002 Parameter IDLE_LIMIT, default 8: number of consecutive RUN cycles with no retirement that ends the program.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 start_i  input  1  CPU start level, the same signal that drives CPU.start_i.
REQ-006 clear_i  input  1  synchronous counter clear.
REQ-007 stall_i  input  1  hazard-detection stall request, this cycle.
REQ-008 branch_i  input  1  Control branch decode, this cycle.
REQ-009 flush_i  input  1  IF/ID flush request, this cycle.
REQ-010 retire_i  input  1  a non-bubble instruction leaves MEM_WB this cycle.
REQ-011 cycle_o  output  WIDTH  count of RUN cycles.
REQ-012 stall_cnt_o  output  WIDTH  count of counted stall cycles.
REQ-013 flush_cnt_o  output  WIDTH  count of flush cycles.
REQ-014 retire_cnt_o  output  WIDTH  count of retired instructions.
REQ-015 running_o  output  1  high while the state is RUN.
REQ-016 done_o  output  1  high while the state is DONE.
REQ-017 sat_o  output  1  sticky flag: any counter has reached all-ones.

Function
REQ-018 The FSM SHALL have three states, IDLE, RUN and DONE, held in a registered state variable.
REQ-019 IDLE transitions: start_i=1 -> RUN at the next edge; no counter changes in the IDLE cycle.
REQ-020 RUN transitions: start_i=0 -> IDLE at the next edge, with all counters held and the idle counter cleared; the cycle in which start_i=0 is sampled is not counted.
REQ-021 RUN with start_i=1 SHALL increment cycle_o by 1 at the edge.
REQ-022 In the same RUN cycle: stall_cnt_o +1 iff stall_i=1 and branch_i=0; flush_cnt_o +1 iff flush_i=1; retire_cnt_o +1 iff retire_i=1.
REQ-023 A stall, flush and retire occurring in the same cycle SHALL each be counted independently.
REQ-024 Idle counter, internal, width clog2(IDLE_LIMIT)+1: in RUN it clears on retire_i=1 and increments otherwise.
REQ-025 When the idle counter equals IDLE_LIMIT-1 and retire_i=0 in a RUN cycle with start_i=1, that cycle SHALL still be counted and the state SHALL become DONE at the edge.
REQ-026 DONE: all counters frozen, inputs other than rst_i and clear_i ignored; DONE exits only via rst_i or clear_i.
REQ-027 Counters SHALL saturate at all-ones; no wrap-around. Reaching all-ones SHALL set sat_o at the same edge, and sat_o SHALL stay set until rst_i or clear_i.
REQ-028 clear_i=1 in any state -> all counters, the idle counter and sat_o go to 0 and the state goes to IDLE at the next edge; that cycle is not counted.
REQ-029 Priority: rst_i > clear_i > FSM/counting.
REQ-030 Outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-031 rst_i=1 at an edge SHALL give: state IDLE; cycle_o, stall_cnt_o, flush_cnt_o, retire_cnt_o = 0; idle counter 0; running_o=0, done_o=0, sat_o=0.
REQ-032 rst_i asserted mid-RUN or in DONE SHALL behave identically to REQ-031 and discard all accumulated counts.

Verification
REQ-033 Reset, then start_i=1 for 10 cycles with retire_i=1 every cycle -> cycle_o=10, retire_cnt_o=10, running_o=1, done_o=0.
REQ-034 In RUN: 3 cycles stall_i=1/branch_i=0, then 2 cycles stall_i=1/branch_i=1, 1 cycle of stall_i+flush_i+retire_i -> stall_cnt_o=4, flush_cnt_o=1, retire_cnt_o=1.
REQ-035 IDLE_LIMIT=8, 5 retiring cycles then retire_i=0 -> done_o=1 after the 8th idle cycle, cycle_o=13; further stimulus leaves all counters unchanged.
REQ-036 WIDTH=4, 20 RUN cycles -> cycle_o=15 and sat_o=1 from the 15th cycle on, with no wrap to 0.
REQ-037 start_i dropped for 3 cycles after 4 RUN cycles, then raised again for 2 cycles -> cycle_o=5 (the re-entry cycle in IDLE is not counted), running_o low during the gap.
REQ-038 clear_i pulsed in DONE -> next cycle: all counters 0, done_o=0, state IDLE; rst_i and clear_i together -> reset result.

Source files
------------

// File: rtl/perf_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | perf_monitor: pipeline performance counters gated by an IDLE/RUN/DONE FSM |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module perf_monitor #(
   parameter int WIDTH      = 32,
   parameter int IDLE_LIMIT = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             clear_i,
   input  logic             stall_i,
   input  logic             branch_i,
   input  logic             flush_i,
   input  logic             retire_i,
   output logic [WIDTH-1:0] cycle_o,
   output logic [WIDTH-1:0] stall_cnt_o,
   output logic [WIDTH-1:0] flush_cnt_o,
   output logic [WIDTH-1:0] retire_cnt_o,
   output logic             running_o,
   output logic             done_o,
   output logic             sat_o
);

   localparam int                IDLE_W    = $clog2(IDLE_LIMIT) + 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);
   localparam logic [WIDTH-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e             state_q,  state_d;
   logic [WIDTH-1:0]   cycle_q,  cycle_d;
   logic [WIDTH-1:0]   stall_q,  stall_d;
   logic [WIDTH-1:0]   flush_q,  flush_d;
   logic [WIDTH-1:0]   retire_q, retire_d;
   logic [IDLE_W-1:0]  idle_q,   idle_d;
   logic               sat_q,    sat_d;

   // Counters stick at all-ones rather than wrapping.
   function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v,
                                                input logic             en);
      if (en && (v != CNT_MAX)) begin
         return v + WIDTH'(1);
      end
      return v;
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         cycle_q  <= '0;
         stall_q  <= '0;
         flush_q  <= '0;
         retire_q <= '0;
         idle_q   <= '0;
         sat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cycle_q  <= cycle_d;
         stall_q  <= stall_d;
         flush_q  <= flush_d;
         retire_q <= retire_d;
         idle_q   <= idle_d;
         sat_q    <= sat_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cycle_d  = cycle_q;
      stall_d  = stall_q;
      flush_d  = flush_q;
      retire_d = retire_q;
      idle_d   = idle_q;
      sat_d    = sat_q;

      if (clear_i) begin
         state_d  = ST_IDLE;
         cycle_d  = '0;
         stall_d  = '0;
         flush_d  = '0;
         retire_d = '0;
         idle_d   = '0;
         sat_d    = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (!start_i) begin
                  state_d = ST_IDLE;
                  idle_d  = '0;
               end else begin
                  // A stall coinciding with a branch decode is not a hazard stall.
                  cycle_d  = sat_inc(cycle_q, 1'b1);
                  stall_d  = sat_inc(stall_q, stall_i & ~branch_i);
                  flush_d  = sat_inc(flush_q, flush_i);
                  retire_d = sat_inc(retire_q, retire_i);
                  sat_d    = sat_q | (cycle_d == CNT_MAX) | (stall_d == CNT_MAX)
                                   | (flush_d == CNT_MAX) | (retire_d == CNT_MAX);
                  if (retire_i) begin
                     idle_d = '0;
                  end else begin
                     idle_d = idle_q + IDLE_W'(1);
                     if (idle_q == IDLE_LAST) begin
                        state_d = ST_DONE;
                     end
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign cycle_o      = cycle_q;
   assign stall_cnt_o  = stall_q;
   assign flush_cnt_o  = flush_q;
   assign retire_cnt_o = retire_q;
   assign running_o    = (state_q == ST_RUN);
   assign done_o       = (state_q == ST_DONE);
   assign sat_o        = sat_q;

endmodule
`default_nettype wire
